// File: rtl/miner_pkg.sv
// Shared definitions for the miner core SHA-256 datapath.
// Holds the word width, round count, the schedule-generator state type and the
// SHA-256 rotate / small-sigma helpers used by the message-schedule logic.
package miner_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 64;
    localparam int BLOCK_W    = 16 * WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } msa_state_t;

    // Rotate right; a shift by the full width yields zero, so n = 0 is safe.
    function automatic word_t ror(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sha_s0(input word_t x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sha_s1(input word_t x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/miner_msa_sigma.sv
// Combinational next-word generator for the SHA-256 message schedule.
// Ports:
//   w0_i   window[0]  = W[t]
//   w1_i   window[1]  = W[t+1]
//   w9_i   window[9]  = W[t+9]
//   w14_i  window[14] = W[t+14]
//   new_o  W[t+16] = s1(w14) + w9 + s0(w1) + w0, mod 2^32
module miner_msa_sigma
    import miner_pkg::*;
(
    input  word_t w0_i,
    input  word_t w1_i,
    input  word_t w9_i,
    input  word_t w14_i,
    output word_t new_o
);

    // Carries out of bit 31 are dropped by the 32-bit result width.
    assign new_o = sha_s1(w14_i) + w9_i + sha_s0(w1_i) + w0_i;

endmodule

// File: rtl/miner_core_msa_gen.sv
// SHA-256 message-schedule generator for the miner core.
// Loads a 512-bit padded block into a 16-word sliding window, then emits one
// schedule word W[t] per advance (msa_en) cycle for t = 0..63.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       capture block_in and (re)start a schedule; wins over msa_en
//   block_in   padded block, word0 in the top 32 bits
//   msa_en     advance enable from the CCU; 0 holds everything
//   w_out      current schedule word W[round_idx] (0 when not running)
//   w_valid    w_out is consumed this cycle
//   round_idx  index of w_out
//   busy       schedule loaded and not finished
//   done       one-cycle pulse after W[63] has been consumed
module miner_core_msa_gen #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64,
    parameter int BLOCK_W    = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] block_in,
    input  logic               msa_en,
    output logic [WORD_W-1:0]  w_out,
    output logic               w_valid,
    output logic [5:0]         round_idx,
    output logic               busy,
    output logic               done
);
    import miner_pkg::*;

    msa_state_t        state_q, state_d;
    logic [WORD_W-1:0] window_q [16];
    logic [WORD_W-1:0] window_d [16];
    logic [5:0]        t_q, t_d;
    logic [WORD_W-1:0] newWord;

    miner_msa_sigma uSigma (
        .w0_i  (window_q[0]),
        .w1_i  (window_q[1]),
        .w9_i  (window_q[9]),
        .w14_i (window_q[14]),
        .new_o (newWord)
    );

    // Next-state logic. The window always holds W[t..t+15], so a consume just
    // shifts down one slot and appends the freshly computed W[t+16]. The shift is
    // skipped on the last consume because nothing beyond W[63] is ever read.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        window_d = window_q;
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                window_d[i] = block_in[BLOCK_W-1-i*WORD_W -: WORD_W];
            end
            t_d     = 6'd0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (msa_en) begin
                        if (t_q == 6'(NUM_ROUNDS - 1)) begin
                            state_d = DONE;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                window_d[i] = window_q[i+1];
                            end
                            window_d[15] = newWord;
                            t_d          = t_q + 6'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset clears the window so outputs are zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            window_q <= window_d;
        end
    end

    // Outputs are gated by RUN so that idle, done and reset all present zeros.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign w_valid   = busy & msa_en;
    assign w_out     = busy ? window_q[0] : '0;
    assign round_idx = busy ? t_q : 6'd0;

endmodule

// File: tb/tb_miner_core_msa_gen.sv
// Self-checking bench for miner_core_msa_gen: an independent SHA-256 schedule
// model fills a scoreboard queue at load time, and entries are popped and
// compared as the DUT emits words.
module tb_miner_core_msa_gen;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } sbEntry_t;

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ZERO = 512'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [511:0] block_in;
    logic         msa_en;
    logic [31:0]  w_out;
    logic         w_valid;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  expW [64];
    sbEntry_t     sb [$];

    miner_core_msa_gen #(.WORD_W(32), .NUM_ROUNDS(64), .BLOCK_W(512)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .block_in  (block_in),
        .msa_en    (msa_en),
        .w_out     (w_out),
        .w_valid   (w_valid),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference schedule, written from the textbook recurrence.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic buildModel(input logic [511:0] blk);
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) expW[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            a = rotr(expW[i-2], 17) ^ rotr(expW[i-2], 19) ^ (expW[i-2] >> 10);
            b = rotr(expW[i-15], 7) ^ rotr(expW[i-15], 18) ^ (expW[i-15] >> 3);
            expW[i] = a + expW[i-7] + b + expW[i-16];
        end
    endtask

    task automatic pushSchedule();
        sbEntry_t e;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            e.idx = 6'(i);
            e.w   = expW[i];
            sb.push_back(e);
        end
    endtask

    // Drive inputs on the falling edge, settle, then the caller samples.
    task automatic drive(input logic ld, input logic en, input logic [511:0] blk);
        @(negedge clk);
        load     = ld;
        msa_en   = en;
        block_in = blk;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; msa_en = 1'b1; block_in = ABC;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({w_out, w_valid, round_idx, busy, done} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got w=%h v=%b idx=%0d busy=%b done=%b want all 0",
                     w_out, w_valid, round_idx, busy, done);
        end
        drive(1'b0, 1'b1, ABC);
        rst = 1'b0;
        drive(1'b0, 1'b1, ABC);
        checks++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignores_en: got busy=%b valid=%b want 0 0", busy, w_valid);
        end
    endtask

    // Consumes the whole scoreboard with continuous msa_en, then checks done.
    task automatic test_full(input string name, input logic [511:0] blk);
        sbEntry_t e;
        buildModel(blk);
        drive(1'b1, 1'b0, blk);
        pushSchedule();
        drive(1'b0, 1'b0, blk);
        checks++;
        if (busy !== 1'b1 || w_valid !== 1'b0 || round_idx !== 6'd0 || w_out !== expW[0]) begin
            errors++;
            $display("[TB] FAIL %s_first_word: got busy=%b v=%b idx=%0d w=%h want 1 0 0 %h",
                     name, busy, w_valid, round_idx, w_out, expW[0]);
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, blk);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s_sb_empty: got empty queue want entry %0d", name, i);
            end else begin
                e = sb.pop_front();
                if (w_valid !== 1'b1 || w_out !== e.w || round_idx !== e.idx || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_word: got v=%b idx=%0d w=%h done=%b want 1 %0d %h 0",
                             name, w_valid, round_idx, w_out, done, e.idx, e.w);
                end
            end
            if (blk == ABC && (i == 16 || i == 17 || i == 18 || i == 63)) begin
                checks++;
                if ((i == 16 && w_out !== 32'h61626380) || (i == 17 && w_out !== 32'h000F0000) ||
                    (i == 18 && w_out !== 32'h7DA86405) || (i == 63 && w_out !== 32'h12B1EDEB)) begin
                    errors++;
                    $display("[TB] FAIL abc_known_W%0d: got %h", i, w_out);
                end
            end
        end
        drive(1'b0, 1'b0, blk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || w_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s_done_pulse: got done=%b busy=%b w=%h want 1 0 0", name, done, busy, w_out);
        end
        drive(1'b0, 1'b1, blk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_done_once: got done=%b busy=%b v=%b want 0 0 0", name, done, busy, w_valid);
        end
    endtask

    task automatic test_stall();
        sbEntry_t e;
        buildModel(ABC);
        drive(1'b1, 1'b0, ABC);
        pushSchedule();
        for (int c = 0; c < 66; c++) begin
            if (c == 17 || c == 18) begin
                drive(1'b0, 1'b0, ABC);
                checks++;
                if (sb.size() == 0 || w_valid !== 1'b0 || w_out !== 32'h000F0000 ||
                    w_out !== sb[0].w || round_idx !== 6'd17) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%b idx=%0d w=%h want 0 17 000f0000",
                             w_valid, round_idx, w_out);
                end
            end else begin
                drive(1'b0, 1'b1, ABC);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stall_sb_empty: got empty queue at cycle %0d", c);
                end else begin
                    e = sb.pop_front();
                    if (w_valid !== 1'b1 || w_out !== e.w || round_idx !== e.idx) begin
                        errors++;
                        $display("[TB] FAIL stall_word: got v=%b idx=%0d w=%h want 1 %0d %h",
                                 w_valid, round_idx, w_out, e.idx, e.w);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, ABC);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done: got %b want 1", done);
        end
    endtask

    task automatic test_reload();
        sbEntry_t e;
        buildModel(ABC);
        drive(1'b1, 1'b0, ABC);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, ABC);
        checks++;
        if (round_idx !== 6'd29) begin
            errors++;
            $display("[TB] FAIL reload_pre_idx: got %0d want 29", round_idx);
        end
        buildModel(ZERO);
        drive(1'b1, 1'b0, ZERO);
        pushSchedule();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, ZERO);
            checks++;
            e = sb.pop_front();
            if (w_out !== e.w || round_idx !== e.idx || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reload_word: got idx=%0d w=%h done=%b busy=%b want %0d %h 0 1",
                         round_idx, w_out, done, busy, e.idx, e.w);
            end
        end
        drive(1'b0, 1'b0, ZERO);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_done: got %b want 1", done);
        end
    endtask

    task automatic test_load_and_en();
        sbEntry_t    e;
        logic [511:0] blk;
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'h9E3779B9 * (i + 1);
        drive(1'b1, 1'b0, ABC);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, ABC);
        buildModel(blk);
        drive(1'b1, 1'b1, blk);
        pushSchedule();
        drive(1'b0, 1'b0, blk);
        checks++;
        if (round_idx !== 6'd0 || w_out !== expW[0] || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_wins: got idx=%0d w=%h busy=%b want 0 %h 1",
                     round_idx, w_out, busy, expW[0]);
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, blk);
            checks++;
            e = sb.pop_front();
            if (w_out !== e.w || round_idx !== e.idx) begin
                errors++;
                $display("[TB] FAIL load_wins_word: got idx=%0d w=%h want %0d %h",
                         round_idx, w_out, e.idx, e.w);
            end
        end
        drive(1'b0, 1'b0, blk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_wins_done: got %b want 1", done);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, ABC);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, ABC);
        drive(1'b0, 1'b1, ABC);
        rst = 1'b1;
        #1;
        checks++;
        if ({w_out, w_valid, round_idx, busy, done} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got w=%h v=%b idx=%0d busy=%b done=%b want all 0",
                     w_out, w_valid, round_idx, busy, done);
        end
        drive(1'b0, 1'b0, ABC);
        rst = 1'b0;
        drive(1'b0, 1'b1, ABC);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got done=%b busy=%b want 0 0", done, busy);
        end
        test_full("abc_after_reset", ABC);
    endtask

    initial begin
        test_reset();
        test_full("abc", ABC);
        test_full("zero", ZERO);
        test_stall();
        test_reload();
        test_load_and_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
